branch_checkpoint_unit: RTL and testbench

Holds rename-state checkpoints for in-flight branches and drives the branch_state_ifc.out view consumed by the misprediction recovery logic. At rename, a branch captures the free-list head and the architectural-to-physical map into a circular checkpoint array. A correctly resolved branch releases its slot. On a misprediction, the unit loads the pruned valid mask and the write pointer computed by recovery. A full flush clears every slot.

---
 rtl/branch_checkpoint_unit_pkg.sv | 37 +++
 rtl/branch_checkpoint_unit_branch_id_match.sv | 32 +++
 rtl/branch_checkpoint_unit.sv | 162 ++++++++++++++++
 tb/tb_branch_checkpoint_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_checkpoint_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_checkpoint_unit_pkg
// Shared sizing constants, the per-slot checkpoint record and a small popcount
// helper used by the branch checkpoint unit and its id comparator.
// ----------------------------------------------------------------------------
package branch_checkpoint_unit_pkg;

  localparam int BRANCH_NUM             = 4;
  localparam int BRANCH_NUM_INDEX       = $clog2(BRANCH_NUM);
  localparam int REG_NUM                = 32;
  localparam int PHYS_REG_NUM           = 64;
  localparam int PHYS_REG_NUM_INDEX     = $clog2(PHYS_REG_NUM);
  localparam int ACTIVE_LIST_SIZE       = 32;
  localparam int ACTIVE_LIST_SIZE_INDEX = $clog2(ACTIVE_LIST_SIZE);
  localparam int MAP_W                  = REG_NUM * PHYS_REG_NUM_INDEX;

  // One checkpoint slot: the branch that owns it, the rename state captured
  // when it was renamed, and whether its delay slot has been renamed since.
  typedef struct packed {
    logic [ACTIVE_LIST_SIZE_INDEX-1:0] branch_id;
    logic [PHYS_REG_NUM_INDEX-1:0]     free_head;
    logic [MAP_W-1:0]                  rename_map;
    logic                              ds_valid;
  } checkpoint_t;

  function automatic logic [BRANCH_NUM_INDEX:0] popcount(
    input logic [BRANCH_NUM-1:0] vec
  );
    logic [BRANCH_NUM_INDEX:0] cnt;
    cnt = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      cnt = cnt + {{BRANCH_NUM_INDEX{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/branch_checkpoint_unit_branch_id_match.sv
// ----------------------------------------------------------------------------
// branch_id_match
// Compares a lookup key against the branch id held in every checkpoint slot.
// Only valid slots can match, and the whole mask is gated by i_en.
//
// Ports:
//   i_en     lookup request this cycle
//   i_valid  slot valid bits
//   i_ids    flattened per-slot branch ids, slot i at [i*ALI +: ALI]
//   i_key    branch id being looked up
//   o_match  per-slot hit mask (one-hot under a well-behaved protocol)
// ----------------------------------------------------------------------------
module branch_id_match
  import branch_checkpoint_unit_pkg::*;
(
  input  logic                                         i_en,
  input  logic [BRANCH_NUM-1:0]                        i_valid,
  input  logic [BRANCH_NUM*ACTIVE_LIST_SIZE_INDEX-1:0] i_ids,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0]            i_key,
  output logic [BRANCH_NUM-1:0]                        o_match
);

  localparam int ALI = ACTIVE_LIST_SIZE_INDEX;

  always_comb begin
    o_match = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      o_match[i] = i_en && i_valid[i] && (i_ids[i*ALI +: ALI] == i_key);
    end
  end

endmodule

// File: rtl/branch_checkpoint_unit.sv
// ----------------------------------------------------------------------------
// branch_checkpoint_unit
// Circular array of rename checkpoints for in-flight branches. Rename captures
// the free-list head and map table of a branch into the slot at write_pointer;
// a correctly resolved branch releases its slot; misprediction recovery loads
// a pruned valid mask and write pointer; a flush empties the array.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   alloc_*              checkpoint allocation from rename (id, free head, map)
//   alloc_ready          slot at write_pointer is free
//   ds_mark/ds_branch_id delay slot of a checkpointed branch was renamed
//   resolve_ok/_id       branch resolved as correctly predicted
//   miss_*               recovery state loaded on a misprediction
//   flush                clear every slot
//   valid, write_pointer, branch_id, free_head_pointer, rename_buffer,
//   ds_valid, occupancy  registered checkpoint state for the recovery logic
// ----------------------------------------------------------------------------
module branch_checkpoint_unit
  import branch_checkpoint_unit_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         alloc_req,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0]            alloc_branch_id,
  input  logic [PHYS_REG_NUM_INDEX-1:0]                alloc_free_head,
  input  logic [MAP_W-1:0]                             alloc_rename_map,
  output logic                                         alloc_ready,
  input  logic                                         ds_mark,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0]            ds_branch_id,
  input  logic                                         resolve_ok,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0]            resolve_branch_id,
  input  logic                                         miss_load,
  input  logic [BRANCH_NUM-1:0]                        miss_valid,
  input  logic [BRANCH_NUM_INDEX-1:0]                  miss_write_pointer,
  input  logic                                         flush,
  output logic [BRANCH_NUM-1:0]                        valid,
  output logic [BRANCH_NUM_INDEX-1:0]                  write_pointer,
  output logic [BRANCH_NUM*ACTIVE_LIST_SIZE_INDEX-1:0] branch_id,
  output logic [BRANCH_NUM*PHYS_REG_NUM_INDEX-1:0]     free_head_pointer,
  output logic [BRANCH_NUM*MAP_W-1:0]                  rename_buffer,
  output logic [BRANCH_NUM-1:0]                        ds_valid,
  output logic [BRANCH_NUM_INDEX:0]                    occupancy
);

  localparam int ALI = ACTIVE_LIST_SIZE_INDEX;
  localparam int PRI = PHYS_REG_NUM_INDEX;
  localparam int BNI = BRANCH_NUM_INDEX;

  checkpoint_t                 r_ckpt [BRANCH_NUM];
  logic [BRANCH_NUM-1:0]       r_valid;
  logic [BNI-1:0]              r_write_pointer;
  logic [BNI:0]                r_occupancy;

  logic [BRANCH_NUM*ALI-1:0]   w_ids;
  logic [BRANCH_NUM-1:0]       w_ds_cur;
  logic [BRANCH_NUM-1:0]       w_ds_mask;
  logic [BRANCH_NUM-1:0]       w_resolve_mask;
  logic [BRANCH_NUM-1:0]       w_alloc_onehot;
  logic                        w_alloc_fire;
  logic                        w_alloc_ds;
  logic [BRANCH_NUM-1:0]       w_valid_nxt;
  logic [BRANCH_NUM-1:0]       w_ds_nxt;
  logic [BNI-1:0]              w_write_pointer_nxt;

  // Flatten the slot array for the comparators and the output view.
  always_comb begin
    w_ids             = '0;
    w_ds_cur          = '0;
    free_head_pointer = '0;
    rename_buffer     = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      w_ids[i*ALI +: ALI]               = r_ckpt[i].branch_id;
      w_ds_cur[i]                       = r_ckpt[i].ds_valid;
      free_head_pointer[i*PRI +: PRI]   = r_ckpt[i].free_head;
      rename_buffer[i*MAP_W +: MAP_W]   = r_ckpt[i].rename_map;
    end
  end

  assign branch_id     = w_ids;
  assign ds_valid      = w_ds_cur;
  assign valid         = r_valid;
  assign write_pointer = r_write_pointer;
  assign occupancy     = r_occupancy;

  // Readiness depends only on registered state, so a slot freed by a resolve
  // this cycle can only be allocated from the next cycle on.
  assign alloc_ready = !r_valid[r_write_pointer];

  branch_id_match u_ds_match (
    .i_en    (ds_mark),
    .i_valid (r_valid),
    .i_ids   (w_ids),
    .i_key   (ds_branch_id),
    .o_match (w_ds_mask)
  );

  branch_id_match u_resolve_match (
    .i_en    (resolve_ok),
    .i_valid (r_valid),
    .i_ids   (w_ids),
    .i_key   (resolve_branch_id),
    .o_match (w_resolve_mask)
  );

  assign w_alloc_fire = alloc_req && alloc_ready && !miss_load && !flush;
  // The comparators only see valid slots, so a delay slot renamed together
  // with its branch is caught here against the incoming id instead.
  assign w_alloc_ds   = ds_mark && (ds_branch_id == alloc_branch_id);

  always_comb begin
    w_alloc_onehot                  = '0;
    w_alloc_onehot[r_write_pointer] = 1'b1;

    w_valid_nxt         = r_valid;
    w_ds_nxt            = w_ds_cur;
    w_write_pointer_nxt = r_write_pointer;

    if (flush) begin
      w_valid_nxt         = '0;
      w_ds_nxt            = '0;
      w_write_pointer_nxt = '0;
    end else if (miss_load) begin
      // A branch that resolves correctly in the recovery cycle is still freed.
      w_valid_nxt         = miss_valid & ~w_resolve_mask;
      w_ds_nxt            = w_ds_cur & w_valid_nxt;
      w_write_pointer_nxt = miss_write_pointer;
    end else begin
      w_valid_nxt = (r_valid & ~w_resolve_mask)
                  | (w_alloc_fire ? w_alloc_onehot : '0);
      w_ds_nxt    = (w_ds_cur | w_ds_mask) & ~w_resolve_mask;
      if (w_alloc_fire) begin
        w_ds_nxt[r_write_pointer] = w_alloc_ds;
        w_write_pointer_nxt       = r_write_pointer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_write_pointer <= '0;
      r_occupancy     <= '0;
      for (int i = 0; i < BRANCH_NUM; i++) begin
        r_ckpt[i] <= '0;
      end
    end else begin
      r_valid         <= w_valid_nxt;
      r_write_pointer <= w_write_pointer_nxt;
      r_occupancy     <= popcount(w_valid_nxt);
      for (int i = 0; i < BRANCH_NUM; i++) begin
        r_ckpt[i].ds_valid <= w_ds_nxt[i];
        if (w_alloc_fire && (r_write_pointer == BNI'(i))) begin
          r_ckpt[i].branch_id  <= alloc_branch_id;
          r_ckpt[i].free_head  <= alloc_free_head;
          r_ckpt[i].rename_map <= alloc_rename_map;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_unit.sv
module tb_branch_checkpoint_unit;
  import branch_checkpoint_unit_pkg::*;

  localparam int BN  = BRANCH_NUM;
  localparam int BNI = BRANCH_NUM_INDEX;
  localparam int ALI = ACTIVE_LIST_SIZE_INDEX;
  localparam int PRI = PHYS_REG_NUM_INDEX;
  localparam int MW  = MAP_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alloc_req;
  logic [ALI-1:0]    alloc_branch_id;
  logic [PRI-1:0]    alloc_free_head;
  logic [MW-1:0]     alloc_rename_map;
  logic              alloc_ready;
  logic              ds_mark;
  logic [ALI-1:0]    ds_branch_id;
  logic              resolve_ok;
  logic [ALI-1:0]    resolve_branch_id;
  logic              miss_load;
  logic [BN-1:0]     miss_valid;
  logic [BNI-1:0]    miss_write_pointer;
  logic              flush;
  logic [BN-1:0]     valid;
  logic [BNI-1:0]    write_pointer;
  logic [BN*ALI-1:0] branch_id;
  logic [BN*PRI-1:0] free_head_pointer;
  logic [BN*MW-1:0]  rename_buffer;
  logic [BN-1:0]     ds_valid;
  logic [BNI:0]      occupancy;

  branch_checkpoint_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alloc_req          (alloc_req),
    .alloc_branch_id    (alloc_branch_id),
    .alloc_free_head    (alloc_free_head),
    .alloc_rename_map   (alloc_rename_map),
    .alloc_ready        (alloc_ready),
    .ds_mark            (ds_mark),
    .ds_branch_id       (ds_branch_id),
    .resolve_ok         (resolve_ok),
    .resolve_branch_id  (resolve_branch_id),
    .miss_load          (miss_load),
    .miss_valid         (miss_valid),
    .miss_write_pointer (miss_write_pointer),
    .flush              (flush),
    .valid              (valid),
    .write_pointer      (write_pointer),
    .branch_id          (branch_id),
    .free_head_pointer  (free_head_pointer),
    .rename_buffer      (rename_buffer),
    .ds_valid           (ds_valid),
    .occupancy          (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BN-1:0]     valid;
    logic [BNI-1:0]    wp;
    logic [BNI:0]      occ;
    logic [BN-1:0]     ds;
    logic              ready;
    logic [BN*ALI-1:0] bid;
    logic [BN*PRI-1:0] fh;
    logic [BN*MW-1:0]  rb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: a plain array of slots plus an integer pointer.
  bit             m_valid [BN];
  bit             m_ds    [BN];
  logic [ALI-1:0] m_id    [BN];
  logic [PRI-1:0] m_fh    [BN];
  logic [MW-1:0]  m_map   [BN];
  int             m_wp;

  task automatic check(input string name, input logic [BN*MW-1:0] act,
                       input logic [BN*MW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int   cnt;
    e   = '0;
    cnt = 0;
    for (int i = 0; i < BN; i++) begin
      e.valid[i]            = m_valid[i];
      e.ds[i]               = m_ds[i];
      e.bid[i*ALI +: ALI]   = m_id[i];
      e.fh[i*PRI +: PRI]    = m_fh[i];
      e.rb[i*MW +: MW]      = m_map[i];
      if (m_valid[i]) cnt++;
    end
    e.wp    = BNI'(m_wp);
    e.occ   = (BNI+1)'(cnt);
    e.ready = !m_valid[m_wp];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BN; i++) begin
      m_valid[i] = 0;
      m_ds[i]    = 0;
      m_id[i]    = '0;
      m_fh[i]    = '0;
      m_map[i]   = '0;
    end
    m_wp = 0;
  endtask

  // Applies the current input values to the model as one clock edge and
  // queues the state the DUT must show after that edge.
  task automatic model_step();
    bit rclr [BN];
    bit ready;
    int nres, nds;
    nres = 0;
    nds  = 0;
    for (int i = 0; i < BN; i++) begin
      rclr[i] = resolve_ok && m_valid[i] && (m_id[i] == resolve_branch_id);
      if (rclr[i]) nres++;
      if (ds_mark && m_valid[i] && (m_id[i] == ds_branch_id)) nds++;
    end
    assert (nres <= 1 && nds <= 1)
      else $error("FAIL protocol: multiple slots share a branch id");
    ready = !m_valid[m_wp];
    if (flush) begin
      for (int i = 0; i < BN; i++) begin
        m_valid[i] = 0;
        m_ds[i]    = 0;
      end
      m_wp = 0;
    end else if (miss_load) begin
      for (int i = 0; i < BN; i++) begin
        m_valid[i] = miss_valid[i] && !rclr[i];
        if (!m_valid[i]) m_ds[i] = 0;
      end
      m_wp = int'(miss_write_pointer);
    end else begin
      for (int i = 0; i < BN; i++)
        if (ds_mark && m_valid[i] && m_id[i] == ds_branch_id) m_ds[i] = 1;
      for (int i = 0; i < BN; i++)
        if (rclr[i]) begin
          m_valid[i] = 0;
          m_ds[i]    = 0;
        end
      if (alloc_req && ready) begin
        m_id[m_wp]    = alloc_branch_id;
        m_fh[m_wp]    = alloc_free_head;
        m_map[m_wp]   = alloc_rename_map;
        m_valid[m_wp] = 1;
        m_ds[m_wp]    = ds_mark && (ds_branch_id == alloc_branch_id);
        m_wp          = (m_wp + 1) % BN;
      end
    end
    sb_q.push_back(model_view());
  endtask

  // Monitor: every edge (and every reset assertion) presents a new state.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("valid",             BN*MW'(valid),             BN*MW'(e.valid));
        check("write_pointer",     BN*MW'(write_pointer),     BN*MW'(e.wp));
        check("occupancy",         BN*MW'(occupancy),         BN*MW'(e.occ));
        check("ds_valid",          BN*MW'(ds_valid),          BN*MW'(e.ds));
        check("alloc_ready",       BN*MW'(alloc_ready),       BN*MW'(e.ready));
        check("branch_id",         BN*MW'(branch_id),         BN*MW'(e.bid));
        check("free_head_pointer", BN*MW'(free_head_pointer), BN*MW'(e.fh));
        check("rename_buffer",     rename_buffer,             e.rb);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alloc_req          = 1'b0;
    alloc_branch_id    = '0;
    alloc_free_head    = '0;
    alloc_rename_map   = '0;
    ds_mark            = 1'b0;
    ds_branch_id       = '0;
    resolve_ok         = 1'b0;
    resolve_branch_id  = '0;
    miss_load          = 1'b0;
    miss_valid         = '0;
    miss_write_pointer = '0;
    flush              = 1'b0;
  endtask

  function automatic logic [MW-1:0] rand_map();
    logic [MW-1:0] m;
    for (int k = 0; k < MW/32; k++) m[k*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic set_alloc(input int id);
    alloc_req        = 1'b1;
    alloc_branch_id  = ALI'(id);
    alloc_free_head  = PRI'($urandom);
    alloc_rename_map = rand_map();
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    idle();
  endtask

  function automatic bit id_in_use(input logic [ALI-1:0] id);
    for (int i = 0; i < BN; i++)
      if (m_valid[i] && m_id[i] == id) return 1;
    return 0;
  endfunction

  function automatic logic [ALI-1:0] pick_id();
    int s;
    s = $urandom_range(0, BN - 1);
    if ($urandom_range(0, 99) < 70 && m_valid[s]) return m_id[s];
    return ALI'($urandom);
  endfunction

  task automatic rand_cycle();
    logic [ALI-1:0] id;
    logic [BN-1:0]  vmask;
    do id = ALI'($urandom); while (id_in_use(id));
    vmask = '0;
    for (int i = 0; i < BN; i++) vmask[i] = m_valid[i];
    alloc_req          = ($urandom_range(0, 99) < 60);
    alloc_branch_id    = id;
    alloc_free_head    = PRI'($urandom);
    alloc_rename_map   = rand_map();
    ds_mark            = ($urandom_range(0, 99) < 30);
    ds_branch_id       = ($urandom_range(0, 99) < 25) ? id : pick_id();
    resolve_ok         = ($urandom_range(0, 99) < 35);
    resolve_branch_id  = pick_id();
    miss_load          = ($urandom_range(0, 99) < 8);
    miss_valid         = BN'($urandom) & vmask;
    miss_write_pointer = BNI'($urandom);
    flush              = ($urandom_range(0, 99) < 2);
  endtask

  initial begin
    int ids [4];
    ids = '{3, 7, 9, 12};
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then fill all four slots.
    tick();
    for (int k = 0; k < 4; k++) begin
      set_alloc(ids[k]);
      tick();
    end
    // Full: request is refused.
    set_alloc(20);
    tick();

    // Free slot 0, then reuse it.
    resolve_ok = 1'b1; resolve_branch_id = ALI'(3);
    tick();
    set_alloc(14);
    tick();

    // Delay slot on slot 2, free slot 3, then recover with a pruned mask
    // while rename keeps requesting.
    ds_mark = 1'b1; ds_branch_id = ALI'(9);
    tick();
    resolve_ok = 1'b1; resolve_branch_id = ALI'(12);
    tick();
    set_alloc(21);
    miss_load = 1'b1; miss_valid = 4'b0011; miss_write_pointer = 2'd2;
    ds_mark = 1'b1; ds_branch_id = ALI'(21);
    tick();

    // Allocation and its delay slot together; then an unmatched delay slot.
    set_alloc(5);
    ds_mark = 1'b1; ds_branch_id = ALI'(5);
    tick();
    ds_mark = 1'b1; ds_branch_id = ALI'(6);
    tick();

    // Flush beats both recovery and allocation.
    set_alloc(22);
    miss_load = 1'b1; miss_valid = 4'b1111; miss_write_pointer = 2'd3;
    flush = 1'b1;
    tick();

    // Two slots valid, then reset in the middle of an allocation.
    set_alloc(1);
    tick();
    set_alloc(2);
    tick();
    set_alloc(11);
    #2;
    model_reset();
    sb_q.push_back(model_view());
    rst_n = 1'b0;
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
    set_alloc(4);
    tick();
    set_alloc(8);
    ds_mark = 1'b1; ds_branch_id = ALI'(4);
    tick();

    repeat (3000) begin
      rand_cycle();
      tick();
    end

    @(negedge clk);
    check("scoreboard_drained", BN*MW'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
